// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction SRAM-like bus
// and hands one instruction per strobe to decode.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter logic [31:0] EXC_PC   = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] new_pc,
  input  logic        PCWriteCond,
  input  logic        stop,
  input  logic        b_stop,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        sweap,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic [31:0] pc_o,
  output logic [31:0] pc_4_o,
  output logic [31:0] inst_o,
  output logic        pc_valid_o,
  output logic [7:0]  tag_o,
  output logic [31:0] badvaddr_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] ftgt_q, ftgt_d;
  logic        lock_q, lock_d;
  logic [31:0] buf_q, buf_d;
  logic        buf_v_q, buf_v_d;
  logic        discard_q, discard_d;

  logic        pv_q, pv_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] inst_q, inst_d;
  logic        adel_q, adel_d;
  logic [31:0] badv_q, badv_d;

  logic        stall;
  logic        flush;
  logic [31:0] flush_tgt;
  logic        eff_pv;
  logic [31:0] eff_tgt;
  logic [31:0] seq_pc;
  logic [31:0] nxt_pc;
  logic        fpc_mis;
  logic        nxt_mis;
  logic        take;
  logic        chain;
  logic        req_pend;
  logic        wait_nodat;

  assign stall     = stop | b_stop;
  assign flush     = sweap | eret;
  assign flush_tgt = sweap ? EXC_PC : epc;
  // a redirect raised this cycle already steers the fetch after the delay slot
  assign eff_pv    = pend_v_q | PCWriteCond;
  assign eff_tgt   = PCWriteCond ? new_pc : pend_tgt_q;
  assign seq_pc    = fpc_q + 32'd4;
  assign nxt_pc    = eff_pv ? eff_tgt : seq_pc;
  assign fpc_mis   = |fpc_q[1:0];
  assign nxt_mis   = |nxt_pc[1:0];

  assign take = (state_q == S_WAIT)
              & inst_sram_data_ok
              & ~discard_q
              & ~flush;
  assign chain      = take & ~stall & ~nxt_mis;
  assign req_pend   = (state_q == S_REQ) & ~fpc_mis;
  assign wait_nodat = (state_q == S_WAIT) & ~inst_sram_data_ok;

  assign inst_sram_req  = req_pend | chain;
  assign inst_sram_addr = chain    ? nxt_pc :
                          req_pend ? fpc_q  :
                                     32'd0;

  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    pend_tgt_d = pend_tgt_q;
    pend_v_d   = pend_v_q;
    ftgt_d     = ftgt_q;
    lock_d     = lock_q;
    buf_d      = buf_q;
    buf_v_d    = buf_v_q;
    discard_d  = discard_q;
    pv_d       = 1'b0;
    pc_d       = 32'd0;
    pc4_d      = 32'd0;
    inst_d     = 32'd0;
    adel_d     = 1'b0;
    badv_d     = 32'd0;

    if (PCWriteCond && !lock_q && !discard_q) begin
      pend_v_d   = 1'b1;
      pend_tgt_d = new_pc;
    end

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (lock_q) begin
          if (inst_sram_addr_ok) begin
            fpc_d     = ftgt_q;
            lock_d    = 1'b0;
            discard_d = 1'b1;
            state_d   = S_WAIT;
          end
        end else if (fpc_mis) begin
          if (!stall) begin
            pv_d    = 1'b1;
            pc_d    = fpc_q;
            pc4_d   = seq_pc;
            adel_d  = 1'b1;
            badv_d  = fpc_q;
            state_d = S_FAULT;
          end
        end else if (inst_sram_addr_ok) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (inst_sram_data_ok) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else if (stall) begin
            buf_d   = inst_sram_rdata;
            buf_v_d = 1'b1;
            state_d = S_HOLD;
          end else begin
            pv_d     = 1'b1;
            pc_d     = fpc_q;
            pc4_d    = seq_pc;
            inst_d   = inst_sram_rdata;
            fpc_d    = nxt_pc;
            pend_v_d = 1'b0;
            state_d  = (chain && inst_sram_addr_ok)
                     ? S_WAIT : S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          pv_d     = buf_v_q;
          pc_d     = buf_v_q ? fpc_q : 32'd0;
          pc4_d    = buf_v_q ? seq_pc : 32'd0;
          inst_d   = buf_v_q ? buf_q : 32'd0;
          buf_v_d  = 1'b0;
          fpc_d    = nxt_pc;
          pend_v_d = 1'b0;
          state_d  = S_REQ;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // an accepted or still-pending bus request is never altered; the new
    // target waits behind it and the stale data is dropped via discard
    if (flush) begin
      pend_v_d = 1'b0;
      buf_v_d  = 1'b0;
      pv_d     = 1'b0;
      pc_d     = 32'd0;
      pc4_d    = 32'd0;
      inst_d   = 32'd0;
      adel_d   = 1'b0;
      badv_d   = 32'd0;
      unique case (1'b1)
        req_pend && !inst_sram_addr_ok: begin
          lock_d    = 1'b1;
          ftgt_d    = flush_tgt;
          fpc_d     = fpc_q;
          discard_d = 1'b0;
          state_d   = S_REQ;
        end
        (req_pend && inst_sram_addr_ok) || wait_nodat: begin
          lock_d    = 1'b0;
          fpc_d     = flush_tgt;
          discard_d = 1'b1;
          state_d   = S_WAIT;
        end
        default: begin
          lock_d    = 1'b0;
          fpc_d     = flush_tgt;
          discard_d = 1'b0;
          state_d   = S_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      fpc_q      <= RESET_PC;
      pend_tgt_q <= 32'd0;
      pend_v_q   <= 1'b0;
      ftgt_q     <= 32'd0;
      lock_q     <= 1'b0;
      buf_q      <= 32'd0;
      buf_v_q    <= 1'b0;
      discard_q  <= 1'b0;
      pv_q       <= 1'b0;
      pc_q       <= 32'd0;
      pc4_q      <= 32'd0;
      inst_q     <= 32'd0;
      adel_q     <= 1'b0;
      badv_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      pend_tgt_q <= pend_tgt_d;
      pend_v_q   <= pend_v_d;
      ftgt_q     <= ftgt_d;
      lock_q     <= lock_d;
      buf_q      <= buf_d;
      buf_v_q    <= buf_v_d;
      discard_q  <= discard_d;
      pv_q       <= pv_d;
      pc_q       <= pc_d;
      pc4_q      <= pc4_d;
      inst_q     <= inst_d;
      adel_q     <= adel_d;
      badv_q     <= badv_d;
    end
  end

  assign pc_valid_o = pv_q;
  assign pc_o       = pc_q;
  assign pc_4_o     = pc4_q;
  assign inst_o     = inst_q;
  assign tag_o      = {adel_q, 7'd0};
  assign badvaddr_o = badv_q;

endmodule
